// File: rtl/cim_pkg.sv
// ============================================================================
// cim_pkg : constants and types shared by the CIM bank and its loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package cim_pkg;

    localparam int unsigned CIM_ROWS = 8;
    localparam int unsigned CIM_DW   = 24;

    // Burst length used when row_cnt is programmed as zero.
    localparam int unsigned ROW_CNT_ZERO_LEN = CIM_ROWS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/cim_onehot_dec.sv
// ============================================================================
// cim_onehot_dec : combinational row-index to one-hot decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module cim_onehot_dec
    import cim_pkg::*;
#(
    parameter int unsigned ROWS = CIM_ROWS,
    localparam int unsigned SELW = $clog2(ROWS)
) (
    input  logic [SELW-1:0] sel,
    output logic [ROWS-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

`default_nettype wire

// File: rtl/cim_weight_loader.sv
// ============================================================================
// cim_weight_loader : streams raw weights into one-hot row writes of the bank
// Revision: 1.0
// ============================================================================
`default_nettype none

module cim_weight_loader
    import cim_pkg::*;
#(
    parameter int unsigned ROWS = CIM_ROWS,
    parameter int unsigned DW   = CIM_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      base_row,
    input  logic [2:0]      row_cnt,
    input  logic            s_valid,
    input  logic [DW-1:0]   s_data,
    output logic            s_ready,
    output logic [ROWS-1:0] WA,
    output logic [DW-1:0]   D,
    output logic            busy,
    output logic            done
);

    loader_state_t   state;
    loader_state_t   state_nxt;
    logic [2:0]      ptr;
    logic [3:0]      remain;
    logic [3:0]      remain_load;
    logic [ROWS-1:0] ptr_onehot;
    logic            hs;

    assign s_ready     = (state == ST_LOAD);
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign hs          = s_valid && s_ready;
    assign remain_load = (row_cnt == 3'd0) ? 4'(ROW_CNT_ZERO_LEN) : {1'b0, row_cnt};

    cim_onehot_dec #(
        .ROWS   (ROWS)
    ) u_dec (
        .sel    (ptr),
        .onehot (ptr_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD:  if (hs && (remain == 4'd1)) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // WA pulses for one cycle per accepted beat; D keeps the last written word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            remain <= '0;
            WA     <= '0;
            D      <= '0;
        end else begin
            WA <= '0;
            if ((state == ST_IDLE) && start) begin
                ptr    <= base_row;
                remain <= remain_load;
            end
            if (hs) begin
                WA     <= ptr_onehot;
                D      <= s_data;
                ptr    <= ptr + 3'd1;
                remain <= remain - 4'd1;
            end
        end
    end

endmodule

`default_nettype wire
